// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares the UART TX FIFO write port between two message sources (the
//   debugger response stream and a dump streamer). Each source offers a
//   1-4 byte message (32-bit word + size code). A round-robin arbiter grants
//   the port. The granted message is written to the FIFO most-significant
//   byte first, and the source gets a one-cycle ack. Messages from the two
//   sources never interleave.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   req0/1     in   request, held high until the matching ack
//   data0/1    in   [31:0] message word, sampled only at grant
//   size0/1    in   [1:0] byte count minus one
//   ack0/1     out  one-cycle pulse, message fully written
//   wr_full    in   TX FIFO full
//   wr         out  FIFO write strobe (combinational on wr_full)
//   w_data     out  [7:0] FIFO write data
//   busy       out  high while a message is owned (state != IDLE)
//   grant      out  owner of the current message, valid while busy
//   dbg_state  out  [1:0] FSM state: 0 IDLE, 1 SEND, 2 DONE
//
// Handshake: a source raises reqN and holds it and its data/size. The data is
// captured on the edge that leaves IDLE. The source samples ackN=1 during
// DONE and drops reqN on that same edge, so reqN is already low in the IDLE
// cycle that follows. The FIFO side is plain valid/full: a byte transfers
// on every rising edge where wr=1, which means SEND and !wr_full.
// ---------------------------------------------------------------------------
module uart_tx_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic [1:0]  size0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] data1,
  input  logic [1:0]  size1,
  output logic        ack1,
  input  logic        wr_full,
  output logic        wr,
  output logic [7:0]  w_data,
  output logic        busy,
  output logic        grant,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_shift;
  logic [1:0]  r_cnt;
  logic        r_grant;
  logic        r_ptr;     // last client served; reset to 1 so client 0 wins the first tie

  logic        w_any;
  logic        w_pick;
  logic [31:0] w_sel_data;
  logic [1:0]  w_sel_size;
  logic [31:0] w_aligned;

  // Arbitration: a lone requester wins. On a tie, the client not served last wins.
  always_comb begin
    w_any  = req0 | req1;
    w_pick = 1'b0;
    if (req0 && req1) begin
      w_pick = ~r_ptr;
    end else begin
      w_pick = req1;
    end
    w_sel_data = w_pick ? data1 : data0;
    w_sel_size = w_pick ? size1 : size0;
    // Left-justify the message so its first byte sits in [31:24].
    w_aligned = w_sel_data;
    case (w_sel_size)
      2'd0:    w_aligned = {w_sel_data[7:0],  24'h000000};
      2'd1:    w_aligned = {w_sel_data[15:0], 16'h0000};
      2'd2:    w_aligned = {w_sel_data[23:0], 8'h00};
      default: w_aligned = w_sel_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_shift <= 32'h0;
      r_cnt   <= 2'd0;
      r_grant <= 1'b0;
      r_ptr   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_shift <= w_aligned;
            r_cnt   <= w_sel_size;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          // A full FIFO stalls everything, so w_data stays on the pending byte.
          if (!wr_full) begin
            r_shift <= {r_shift[23:0], 8'h00};
            if (r_cnt == 2'd0) begin
              r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt - 2'd1;
            end
          end
        end
        ST_DONE: begin
          r_ptr   <= r_grant;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The shift register is empty outside SEND, so w_data reads 0 when idle.
  assign wr        = (r_state == ST_SEND) && !wr_full;
  assign w_data    = r_shift[31:24];
  assign ack0      = (r_state == ST_DONE) && !r_grant;
  assign ack1      = (r_state == ST_DONE) &&  r_grant;
  assign busy      = (r_state != ST_IDLE);
  assign grant     = r_grant;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [31:0] data0, data1;
  logic [1:0]  size0, size1;
  logic        ack0, ack1;
  logic        wr_full;
  logic        wr;
  logic [7:0]  w_data;
  logic        busy;
  logic        grant;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .data0     (data0),
    .size0     (size0),
    .ack0      (ack0),
    .req1      (req1),
    .data1     (data1),
    .size1     (size1),
    .ack1      (ack1),
    .wr_full   (wr_full),
    .wr        (wr),
    .w_data    (w_data),
    .busy      (busy),
    .grant     (grant),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks one cycle at the falling edge, then advances to just after the
  // next rising edge, where the caller may change inputs.
  task automatic step(input string tag, input logic ewr, input logic [7:0] ewd,
                      input logic ea0, input logic ea1, input logic ebusy,
                      input logic egr);
    @(negedge clk);
    check({tag, ".wr"},     {31'h0, wr},    {31'h0, ewr});
    check({tag, ".w_data"}, {24'h0, w_data}, {24'h0, ewd});
    check({tag, ".ack0"},   {31'h0, ack0},  {31'h0, ea0});
    check({tag, ".ack1"},   {31'h0, ack1},  {31'h0, ea1});
    check({tag, ".busy"},   {31'h0, busy},  {31'h0, ebusy});
    if (ebusy) check({tag, ".grant"}, {31'h0, grant}, {31'h0, egr});
    @(posedge clk);
    #1;
  endtask

  // Expected bytes are given left-justified in exp_w, first byte in [31:24].
  task automatic send_bytes(input string tag, input logic cl, input logic [31:0] exp_w,
                            input int n);
    for (int i = 0; i < n; i++) begin
      step($sformatf("%s.b%0d", tag, i), 1'b1, exp_w[31-8*i -: 8], 1'b0, 1'b0, 1'b1, cl);
    end
  endtask

  // Single-client message; the port is idle at entry and at exit.
  task automatic send_msg(input string tag, input logic cl, input logic [31:0] d,
                          input logic [1:0] sz, input logic [31:0] exp_w, input int n);
    if (cl) begin req1 = 1'b1; data1 = d; size1 = sz; end
    else    begin req0 = 1'b1; data0 = d; size0 = sz; end
    step({tag, ".idle"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    // Scramble the source after grant; the message in flight must not change.
    if (cl) begin data1 = 32'h0; size1 = 2'd0; end
    else    begin data0 = 32'h0; size0 = 2'd0; end
    send_bytes(tag, cl, exp_w, n);
    step({tag, ".ack"}, 1'b0, 8'h00, !cl, cl, 1'b1, cl);
    if (cl) req1 = 1'b0; else req0 = 1'b0;
    step({tag, ".after"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Both clients request together; client 0 is expected to win first.
  task automatic tie_pair(input string tag,
                          input logic [31:0] d0, input logic [1:0] s0, input logic [31:0] e0, input int n0,
                          input logic [31:0] d1, input logic [1:0] s1, input logic [31:0] e1, input int n1);
    req0 = 1'b1; data0 = d0; size0 = s0;
    req1 = 1'b1; data1 = d1; size1 = s1;
    step({tag, ".idle0"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bytes({tag, ".c0"}, 1'b0, e0, n0);
    step({tag, ".ack0"}, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    req0 = 1'b0;
    step({tag, ".idle1"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bytes({tag, ".c1"}, 1'b1, e1, n1);
    step({tag, ".ack1"}, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    req1 = 1'b0;
    step({tag, ".after"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    data0 = 32'h0; data1 = 32'h0; size0 = 2'd0; size1 = 2'd0;
    wr_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.state", {30'h0, dbg_state}, 32'd0);
    reset = 1'b1;
    step("rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.grant", {31'h0, grant}, 32'd0);

    // Simultaneous requests straight after reset: 0 then 1, twice.
    tie_pair("tie1", 32'h11223344, 2'd3, 32'h11223344, 4, 32'hAABBCCDD, 2'd3, 32'hAABBCCDD, 4);
    tie_pair("tie2", 32'h01020304, 2'd1, 32'h03040000, 2, 32'h05060708, 2'd0, 32'h08000000, 1);

    // Single-client messages of several sizes.
    send_msg("c0_4b", 1'b0, 32'hDEADBEEF, 2'd3, 32'hDEADBEEF, 4);
    send_msg("c1_1b", 1'b1, 32'h12345678, 2'd0, 32'h78000000, 1);
    send_msg("c1_2b", 1'b1, 32'h12345678, 2'd1, 32'h56780000, 2);
    send_msg("c0_3b", 1'b0, 32'hCAFEF00D, 2'd2, 32'hFEF00D00, 3);

    // Back-pressure: FIFO full for 3 cycles after the second byte.
    req0 = 1'b1; data0 = 32'hDEADBEEF; size0 = 2'd3;
    step("bp.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step("bp.b0", 1'b1, 8'hDE, 1'b0, 1'b0, 1'b1, 1'b0);
    step("bp.b1", 1'b1, 8'hAD, 1'b0, 1'b0, 1'b1, 1'b0);
    wr_full = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("bp.stall%0d", i), 1'b0, 8'hBE, 1'b0, 1'b0, 1'b1, 1'b0);
    wr_full = 1'b0;
    step("bp.b2", 1'b1, 8'hBE, 1'b0, 1'b0, 1'b1, 1'b0);
    step("bp.b3", 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0);
    step("bp.ack", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    req0 = 1'b0;
    step("bp.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Client 1 arrives mid-message and waits for client 0 to finish.
    req0 = 1'b1; data0 = 32'hDEADBEEF; size0 = 2'd3;
    step("mid.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mid.b0", 1'b1, 8'hDE, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mid.b1", 1'b1, 8'hAD, 1'b0, 1'b0, 1'b1, 1'b0);
    req1 = 1'b1; data1 = 32'hCAFEF00D; size1 = 2'd1;
    step("mid.b2", 1'b1, 8'hBE, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mid.b3", 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mid.ack0", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    req0 = 1'b0;
    step("mid.gap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mid.c1b0", 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("mid.c1b1", 1'b1, 8'h0D, 1'b0, 1'b0, 1'b1, 1'b1);
    step("mid.ack1", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    req1 = 1'b0;
    step("mid.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a message. The message before it leaves the
    // pointer at client 0, so a client 0 win afterwards needs the pointer reset.
    send_msg("pre", 1'b0, 32'h000000A5, 2'd0, 32'hA5000000, 1);
    req0 = 1'b1; data0 = 32'hDEADBEEF; size0 = 2'd3;
    step("ar.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ar.b0", 1'b1, 8'hDE, 1'b0, 1'b0, 1'b1, 1'b0);
    step("ar.b1", 1'b1, 8'hAD, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    req0  = 1'b0;
    #1;
    check("ar.wr",     {31'h0, wr},     32'd0);
    check("ar.w_data", {24'h0, w_data}, 32'd0);
    check("ar.busy",   {31'h0, busy},   32'd0);
    check("ar.ack0",   {31'h0, ack0},   32'd0);
    check("ar.ack1",   {31'h0, ack1},   32'd0);
    check("ar.grant",  {31'h0, grant},  32'd0);
    check("ar.state",  {30'h0, dbg_state}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("ar.quiet0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ar.quiet1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tie_pair("ar.tie", 32'h11223344, 2'd3, 32'h11223344, 4, 32'hAABBCCDD, 2'd3, 32'hAABBCCDD, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
